// File: rtl/pwm_seq_pkg.sv
// Shared types and helpers for the pwm_seq PWM sequencer.
package pwm_seq_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Width needed to hold values 0..value-1; never narrower than one bit.
    function automatic int clog2_f(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    // Channel c of a table entry is {dir, duty} starting at bit c*(duty_w+1).
    function automatic int ent_lsb(input int c, input int duty_w);
        return c * (duty_w + 1);
    endfunction

    function automatic int dir_ofs(input int duty_w);
        return duty_w;
    endfunction

endpackage

// File: rtl/pwm_seq_if.sv
// Host-side control, table-write and H-bridge output bundle of pwm_seq.
interface pwm_seq_if #(
    parameter int N_CH   = 2,
    parameter int DUTY_W = 8,
    parameter int ADDR_W = 4
);
    localparam int ENT_W = N_CH * (DUTY_W + 1);

    logic              start;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] end_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ENT_W-1:0]  wr_data;
    logic [N_CH-1:0]   spd;
    logic [N_CH-1:0]   dir;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] cur_addr;

    modport master (
        output start, stop, loop_en, end_addr, wr_en, wr_addr, wr_data,
        input  spd, dir, busy, done, cur_addr
    );

    modport slave (
        input  start, stop, loop_en, end_addr, wr_en, wr_addr, wr_data,
        output spd, dir, busy, done, cur_addr
    );

endinterface

// File: rtl/pwm_seq_chan.sv
// One PWM channel: shadow duty/dir, dead window on reversal, registered spd/dir.
module pwm_chan
    import pwm_seq_pkg::*;
#(
    parameter int DUTY_W       = 8,
    parameter int PCNT_W       = 8,
    parameter int DEAD_PERIODS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              per_end,
    input  logic              run_cyc,
    input  logic [PCNT_W-1:0] pcnt,
    input  logic [DUTY_W-1:0] ld_duty,
    input  logic              ld_dir,
    output logic              spd,
    output logic              dir
);
    localparam int CW     = (PCNT_W > DUTY_W) ? PCNT_W : DUTY_W;
    localparam int DEAD_W = clog2_f(DEAD_PERIODS + 1);

    logic [DUTY_W-1:0] duty;
    logic              dir_pend;
    logic [DEAD_W-1:0] dead;
    logic              cmp;

    // Common width makes duty >= PERIOD read as constant high instead of wrapping.
    assign cmp = CW'(pcnt) < CW'(duty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty     <= '0;
            dir_pend <= 1'b0;
            dead     <= '0;
            dir      <= 1'b0;
            spd      <= 1'b0;
        end else begin
            spd <= run_cyc && (dead == '0) && cmp;
            if (load) begin
                duty     <= ld_duty;
                dir_pend <= ld_dir;
                if (ld_dir != dir) begin
                    if (DEAD_PERIODS == 0) dir <= ld_dir;
                    else                   dead <= DEAD_W'(DEAD_PERIODS);
                end else begin
                    dead <= '0;
                end
            end else if (!run_cyc) begin
                dead <= '0;
            end else if (per_end && (dead != '0)) begin
                dead <= dead - 1'b1;
                if (dead == DEAD_W'(1)) dir <= dir_pend;
            end
        end
    end

endmodule

// File: rtl/pwm_seq.sv
// Multi-channel PWM sequencer: table register file, playback FSM and period/step counters.
//   state   | meaning
//   ST_IDLE | outputs low, waiting for start; dir holds its last value
//   ST_RUN  | pcnt/scnt counting, table entries applied step by step
module pwm_seq
    import pwm_seq_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int DUTY_W       = 8,
    parameter int PERIOD       = 200,
    parameter int STEP_DIV     = 50,
    parameter int DEAD_PERIODS = 1,
    parameter int DEPTH        = 16
) (
    input logic       clk,
    input logic       rst,
    pwm_seq_if.slave  bus
);
    localparam int ADDR_W = clog2_f(DEPTH);
    localparam int ENT_W  = N_CH * (DUTY_W + 1);
    localparam int PCNT_W = clog2_f(PERIOD);
    localparam int SCNT_W = clog2_f(STEP_DIV);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIOD - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STEP_DIV - 1);

    logic [ENT_W-1:0]  tbl [DEPTH];
    state_t            state;
    logic [PCNT_W-1:0] pcnt;
    logic [SCNT_W-1:0] scnt;
    logic [ADDR_W-1:0] cur_addr;
    logic              busy;
    logic              done;

    logic [ADDR_W-1:0] end_eff;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] load_addr;
    logic [ENT_W-1:0]  load_ent;
    logic              running;
    logic              per_end;
    logic              step_end;
    logic              last_step;
    logic              finish;
    logic              load;
    logic              run_cyc;
    logic [N_CH-1:0]   spd_c;
    logic [N_CH-1:0]   dir_c;

    if ((1 << ADDR_W) == DEPTH) begin : g_pow2
        assign end_eff = bus.end_addr;
    end else begin : g_clamp
        localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
        assign end_eff = (bus.end_addr > ADDR_LAST) ? ADDR_LAST : bus.end_addr;
    end

    always_comb begin
        running   = (state == ST_RUN);
        per_end   = running && (pcnt == PCNT_LAST);
        step_end  = per_end && (scnt == SCNT_LAST);
        last_step = (cur_addr == end_eff);
        finish    = step_end && last_step && !bus.loop_en && !bus.stop;
        next_addr = last_step ? '0 : cur_addr + 1'b1;
        load_addr = running ? next_addr : '0;
        load      = running ? (step_end && !bus.stop && !finish)
                            : (bus.start && !bus.stop);
        run_cyc   = running && !bus.stop && !finish;
        // Same-edge write is not yet visible here, so a colliding load sees old data.
        load_ent  = tbl[load_addr];
    end

    always_ff @(posedge clk) begin
        if (bus.wr_en) tbl[bus.wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pcnt     <= '0;
            scnt     <= '0;
            cur_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state    <= ST_RUN;
                        busy     <= 1'b1;
                        cur_addr <= '0;
                        pcnt     <= '0;
                        scnt     <= '0;
                    end
                end
                ST_RUN: begin
                    if (bus.stop || finish) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= finish;
                        pcnt  <= '0;
                        scnt  <= '0;
                    end else begin
                        pcnt <= per_end ? '0 : pcnt + 1'b1;
                        if (per_end)  scnt     <= step_end ? '0 : scnt + 1'b1;
                        if (step_end) cur_addr <= next_addr;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        pwm_chan #(
            .DUTY_W      (DUTY_W),
            .PCNT_W      (PCNT_W),
            .DEAD_PERIODS(DEAD_PERIODS)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .load   (load),
            .per_end(per_end),
            .run_cyc(run_cyc),
            .pcnt   (pcnt),
            .ld_duty(load_ent[ent_lsb(c, DUTY_W) +: DUTY_W]),
            .ld_dir (load_ent[ent_lsb(c, DUTY_W) + dir_ofs(DUTY_W)]),
            .spd    (spd_c[c]),
            .dir    (dir_c[c])
        );
    end

    assign bus.spd      = spd_c;
    assign bus.dir      = dir_c;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.cur_addr = cur_addr;

endmodule

// File: tb/tb_pwm_seq.sv
// Self-checking bench for pwm_seq: vector table, directed corner cases, random tables vs a timeline model.
module tb_pwm_seq;
    localparam int N_CH         = 2;
    localparam int DUTY_W       = 8;
    localparam int PERIOD       = 10;
    localparam int STEP_DIV     = 3;
    localparam int DEAD_PERIODS = 1;
    localparam int DEPTH        = 8;
    localparam int ADDR_W       = 3;
    localparam int ENT_W        = N_CH * (DUTY_W + 1);
    localparam int STEP_T       = PERIOD * STEP_DIV;
    localparam int MAXK         = 64;
    localparam int MAXT         = 400;

    typedef struct {
        logic [ENT_W-1:0] e;
        int               hi0;
        int               hi1;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    pwm_seq_if #(.N_CH(N_CH), .DUTY_W(DUTY_W), .ADDR_W(ADDR_W)) bus ();

    pwm_seq #(
        .N_CH(N_CH), .DUTY_W(DUTY_W), .PERIOD(PERIOD), .STEP_DIV(STEP_DIV),
        .DEAD_PERIODS(DEAD_PERIODS), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int               n_checks;
    int               n_pass;
    int               done_cnt;
    int               n_end;
    bit               lp;
    logic [1:0]       dir0;
    logic [1:0]       last_dir;
    logic [ENT_W-1:0] tbl_m    [DEPTH];
    logic [ENT_W-1:0] step_ent [MAXK];
    logic [1:0]       spd_log  [MAXT+1];

    function automatic logic [ENT_W-1:0] ent(input logic d1, input int u1, input logic d0, input int u0);
        return {d1, 8'(u1), d0, 8'(u0)};
    endfunction

    task automatic check(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0d actual=%0h required=%0h", nm, t, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Timeline model: time t counts edges since the start edge; each step is a fixed slice.
    function automatic int step_addr(input int k);
        return lp ? (k % (n_end + 1)) : k;
    endfunction

    function automatic int kcl(input int k);
        return (k < MAXK) ? k : MAXK - 1;
    endfunction

    function automatic logic e_dir(input int k, input int c);
        logic [ENT_W-1:0] e;
        e = step_ent[kcl(k)];
        return e[c*(DUTY_W+1) + DUTY_W];
    endfunction

    function automatic int e_duty(input int k, input int c);
        logic [ENT_W-1:0] e;
        e = step_ent[kcl(k)];
        return int'(e[c*(DUTY_W+1) +: DUTY_W]);
    endfunction

    function automatic logic p_dir(input int k, input int c);
        return (k == 0) ? dir0[c] : e_dir(k - 1, c);
    endfunction

    function automatic int fin_t();
        return lp ? (1 << 30) : (n_end + 1) * STEP_T;
    endfunction

    function automatic logic m_dir(input int t, input int c);
        int tt;
        int k;
        tt = (t >= fin_t()) ? fin_t() - 1 : t;
        k  = tt / STEP_T;
        if (e_dir(k, c) != p_dir(k, c) && (tt % STEP_T) < DEAD_PERIODS * PERIOD) return p_dir(k, c);
        return e_dir(k, c);
    endfunction

    function automatic logic m_spd(input int t, input int c);
        int u;
        int k;
        if (t == 0 || t >= fin_t()) return 1'b0;
        u = t - 1;
        k = u / STEP_T;
        if (e_dir(k, c) != p_dir(k, c) && (u % STEP_T) < DEAD_PERIODS * PERIOD) return 1'b0;
        return (u % PERIOD) < e_duty(k, c);
    endfunction

    function automatic int cnt_hi(input int c, input int t0, input int t1);
        int n;
        n = 0;
        for (int t = t0; t <= t1; t++) n += int'(spd_log[t][c]);
        return n;
    endfunction

    task automatic setup(input int e, input bit l);
        n_end = e;
        lp    = l;
        for (int k = 0; k < MAXK; k++) step_ent[k] = tbl_m[step_addr(k) % DEPTH];
        bus.end_addr = 3'(e);
        bus.loop_en  = l;
    endtask

    // A write at edge tw is seen by every later load of that address, not one on the same edge.
    task automatic apply_write(input int tw, input int a, input logic [ENT_W-1:0] d);
        for (int k = 0; k < MAXK; k++)
            if (k * STEP_T > tw && (step_addr(k) % DEPTH) == a) step_ent[k] = d;
        tbl_m[a] = d;
    endtask

    task automatic wr(input int a, input logic [ENT_W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(a);
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
        tbl_m[a]    = d;
    endtask

    task automatic play(input int ncyc, input int stop_t, input bit stop_start,
                        input int wr_t, input int wa, input logic [ENT_W-1:0] wd);
        logic [1:0] es;
        logic [1:0] ed;
        done_cnt = 0;
        for (int i = 0; i <= MAXT; i++) spd_log[i] = 2'b00;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        last_dir = {m_dir(0, 1), m_dir(0, 0)};
        check("busy_at_start", 0, 32'(bus.busy), 32'd1);
        check("addr_at_start", 0, 32'(bus.cur_addr), 32'd0);
        check("spd_at_start", 0, 32'(bus.spd), 32'd0);
        check("dir_at_start", 0, 32'(bus.dir), 32'(last_dir));
        for (int t = 1; t <= ncyc; t++) begin
            if (t == stop_t) begin
                bus.stop  = 1'b1;
                bus.start = stop_start;
            end
            if (t == wr_t) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 3'(wa);
                bus.wr_data = wd;
                apply_write(t, wa, wd);
            end
            tick();
            bus.stop  = 1'b0;
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            if (t == stop_t) begin
                check("stop_spd", t, 32'(bus.spd), 32'd0);
                check("stop_busy", t, 32'(bus.busy), 32'd0);
                check("stop_done", t, 32'(bus.done), 32'd0);
                check("stop_dir", t, 32'(bus.dir), 32'(last_dir));
                dir0 = last_dir;
                return;
            end
            es = {m_spd(t, 1), m_spd(t, 0)};
            ed = {m_dir(t, 1), m_dir(t, 0)};
            spd_log[t] = bus.spd;
            if (bus.done === 1'b1) done_cnt++;
            check("spd", t, 32'(bus.spd), 32'(es));
            check("dir", t, 32'(bus.dir), 32'(ed));
            check("busy", t, 32'(bus.busy), 32'(t < fin_t()));
            check("done", t, 32'(bus.done), 32'(t == fin_t()));
            if (t < fin_t()) check("cur_addr", t, 32'(bus.cur_addr), 32'(step_addr(t / STEP_T)));
            last_dir = ed;
        end
        dir0 = last_dir;
    endtask

    initial begin
        vec_t vecs [4];
        int   e;
        bit   l;
        int   ncyc;
        int   st;

        n_checks = 0;
        n_pass   = 0;
        dir0     = 2'b00;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.loop_en  = 1'b0;
        bus.end_addr = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        for (int a = 0; a < DEPTH; a++) tbl_m[a] = '0;

        vecs[0] = '{ent(0, 7, 0, 3), 3, 7};
        vecs[1] = '{ent(0, 255, 0, 0), 0, 10};
        vecs[2] = '{ent(0, 9, 0, 10), 10, 9};
        vecs[3] = '{ent(0, 11, 0, 1), 1, 10};

        repeat (2) tick();
        check("rst_spd", 0, 32'(bus.spd), 32'd0);
        check("rst_dir", 0, 32'(bus.dir), 32'd0);
        check("rst_busy", 0, 32'(bus.busy), 32'd0);
        check("rst_done", 0, 32'(bus.done), 32'd0);
        check("rst_addr", 0, 32'(bus.cur_addr), 32'd0);
        rst = 1'b0;
        tick();

        // Single-entry one-shot runs: high time in the second period, one done pulse.
        for (int i = 0; i < 4; i++) begin
            wr(0, vecs[i].e);
            setup(0, 1'b0);
            play(STEP_T + 4, -1, 1'b0, -1, 0, '0);
            check("vec_hi_ch0", i, 32'(cnt_hi(0, PERIOD + 1, 2 * PERIOD)), 32'(vecs[i].hi0));
            check("vec_hi_ch1", i, 32'(cnt_hi(1, PERIOD + 1, 2 * PERIOD)), 32'(vecs[i].hi1));
            check("vec_done_once", i, 32'(done_cnt), 32'd1);
        end

        // Direction reversal on ch0 at step 1.
        wr(0, ent(0, 0, 0, 5));
        wr(1, ent(0, 0, 1, 5));
        setup(1, 1'b0);
        play(2 * STEP_T + 4, -1, 1'b0, -1, 0, '0);
        check("dead_low", 1, 32'(cnt_hi(0, 31, 40)), 32'd0);
        check("dead_resume", 1, 32'(cnt_hi(0, 41, 50)), 32'd5);
        check("dead_dir_final", 1, 32'(bus.dir[0]), 32'd1);

        // Looping over three entries, then stopped.
        wr(0, ent(0, 2, 0, 4));
        wr(1, ent(0, 6, 0, 1));
        wr(2, ent(1, 3, 0, 8));
        setup(2, 1'b1);
        play(4 * STEP_T + 10, 4 * STEP_T + 10, 1'b0, -1, 0, '0);
        check("loop_no_done", 2, 32'(done_cnt), 32'd0);

        // stop and start together in RUN, then a clean replay from entry 0.
        wr(0, ent(0, 4, 0, 7));
        setup(0, 1'b1);
        play(40, 20, 1'b1, -1, 0, '0);
        tick();
        check("contend_idle", 3, 32'(bus.busy), 32'd0);
        setup(0, 1'b1);
        play(35, 35, 1'b0, -1, 0, '0);

        // Write colliding with the load of the same entry.
        wr(0, ent(0, 0, 0, 2));
        setup(0, 1'b1);
        play(100, 100, 1'b0, STEP_T, 0, ent(0, 0, 0, 6));
        check("hazard_old", 4, 32'(cnt_hi(0, 31, 40)), 32'd2);
        check("hazard_new", 4, 32'(cnt_hi(0, 61, 70)), 32'd6);

        // Asynchronous reset in the middle of a period.
        wr(0, ent(1, 9, 1, 9));
        wr(1, ent(1, 9, 1, 9));
        setup(1, 1'b1);
        play(44, -1, 1'b0, -1, 0, '0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_spd", 5, 32'(bus.spd), 32'd0);
        check("arst_dir", 5, 32'(bus.dir), 32'd0);
        check("arst_busy", 5, 32'(bus.busy), 32'd0);
        check("arst_addr", 5, 32'(bus.cur_addr), 32'd0);
        #1;
        rst  = 1'b0;
        dir0 = 2'b00;
        tick();
        check("arst_stays_idle", 5, 32'(bus.busy), 32'd0);

        // Random tables, lengths, loop modes, stops and mid-run writes.
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < DEPTH; a++)
                wr(a, ent(1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 11)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 11))));
            e    = int'($urandom_range(0, DEPTH - 1));
            l    = 1'($urandom_range(0, 1));
            ncyc = l ? int'($urandom_range(40, 200)) : (e + 1) * STEP_T + 3;
            if (l)                           st = ncyc;
            else if ($urandom_range(0, 1) == 1) st = int'($urandom_range(5, ncyc - 4));
            else                             st = -1;
            setup(e, l);
            play(ncyc, st, 1'b0, int'($urandom_range(1, ncyc - 1)), int'($urandom_range(0, DEPTH - 1)),
                 ent(1'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 12))));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_seq.md
# pwm_seq

Parametrised multi-channel PWM sequencer: plays a writable command table of per-channel {direction, duty} entries onto N_CH motor-driver spd/dir pairs. It replaces the fixed single-channel PWM + block-RAM + program-counter chain and its derived slow clocks with one clock and internal period/step counters. Duty updates are glitch-free, applied only at PWM period boundaries. A direction reversal inserts a dead window with spd held low. It sits between the host/config logic and the H-bridge pins.

## Interface
- N_CH, 2: number of PWM channels
- DUTY_W, 8: duty field width per channel
- PERIOD, 200: clk cycles per PWM period (≥2)
- STEP_DIV, 50: PWM periods per table step (≥1)
- DEAD_PERIODS, 1: spd-low periods on direction change (< STEP_DIV)
- DEPTH, 16: table entries; ADDR_W = clog2(DEPTH)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, begin playback at entry 0
- stop  in  1  one-cycle pulse, abort playback
- loop_en  in  1  wrap from end_addr to 0 instead of finishing
- end_addr  in  ADDR_W  last entry played
- wr_en  in  1  table write strobe
- wr_addr  in  ADDR_W  table write address
- wr_data  in  N_CH*(DUTY_W+1)  entry; channel c = bits [c*(DUTY_W+1) +: DUTY_W+1], MSB dir, LSBs duty
- spd  out  N_CH  PWM outputs
- dir  out  N_CH  direction outputs
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on one-shot completion
- cur_addr  out  ADDR_W  entry currently applied

## Operation
- Reset: spd=0, dir=0, busy=0, done=0, cur_addr=0, all counters 0, FSM IDLE. Table contents not reset.
- FSM IDLE → RUN on start. RUN → IDLE on stop, or after the last step of end_addr when loop_en=0; that transition pulses done. stop has priority over start. start is ignored in RUN.
- PWM counter pcnt runs 0..PERIOD-1 in RUN only.
- Channel raw output = (pcnt < duty). duty=0 gives constant low. duty ≥ PERIOD gives constant high (clamp, no wrap).
- Step counter scnt counts completed periods 0..STEP_DIV-1. When scnt reaches STEP_DIV-1 and the period ends, cur_addr advances. At end_addr it wraps to 0 if loop_en, otherwise the block finishes. end_addr ≥ DEPTH is treated as DEPTH-1.
- At each step boundary, including RUN entry, the shadow duty/dir registers load from table[cur_addr_next].
- Per channel, if the new dir ≠ current dir: spd is forced 0 for DEAD_PERIODS periods with the old dir. At the end of the window, dir switches and the new duty applies. The dead window counts toward the step.
- Table write is allowed in any state. It is visible on the next cycle. A load of the same address in the same cycle gets the old data.
- In IDLE, spd=0 and dir holds its last value.

## Timing
- start at edge T: busy=1 and cur_addr=0 at T+1. Entry 0 is loaded with pcnt=0, and the first spd high is at T+2 (spd is registered, 1-cycle latency from pcnt).
- Step length is exactly PERIOD*STEP_DIV cycles. cur_addr changes on the same edge as pcnt wraps to 0.
- stop at T: busy=0 and spd=0 at T+1, and counters clear.
- One-shot end: busy falls and done pulses on the edge where the final period of end_addr ends. spd=0 from that edge.
- Reset mid-operation: all outputs go to reset values asynchronously.

## Structure
- Package pwm_seq_pkg holds the entry field offsets, the FSM state encoding (IDLE, RUN), and the clog2 function.
- Sub-module pwm_chan, instantiated N_CH times, holds the shadow duty/dir, the dead-window counter, the compare, and the output register.
- The top level holds the table register file, the FSM, pcnt, scnt and cur_addr.

## Test plan
Parameters for all scenarios: N_CH=2, DUTY_W=8, PERIOD=10, STEP_DIV=3, DEAD_PERIODS=1, DEPTH=8.
- Basic duty: entry0 = ch0 {0,3}, ch1 {0,7}; end_addr=0, loop_en=0, start → ch0 high 3 of every 10 cycles and ch1 high 7 of every 10, for 3 periods. Then done pulses once, busy=0, spd=00.
- Clamp/extremes: duties 0 and 255 → ch0 constant 0 and ch1 constant 1 through the whole step.
- Direction change: entry0 ch0 {0,5}, entry1 ch0 {1,5} → ch0 spd low for the 10 cycles after cycle 30, dir=0 during that window. dir=1 at cycle 40 and high-time of 5 resumes.
- Loop: entries 0..2, end_addr=2, loop_en=1 → cur_addr sequence 0,1,2,0,1 changes every 30 cycles, with no done pulse.
- Stop/start contention: stop and start asserted in the same cycle during RUN → IDLE next cycle, spd=00. A later start replays from entry 0.
- Write hazard and reset: a write to the entry being loaded on the same edge applies the old value, and the new value applies on the next visit. Asserting rst mid-period clears spd, dir, busy and cur_addr immediately.
